ripple_carry_adder_r: RTL and testbench
=======================================

Name:
ripple_carry_adder_r

Overview:
- Parameterised N-bit ripple-carry adder built from a chain of 1-bit full adders.
- Provides a combinational sum/carry path and a registered copy of the same result with one cycle of latency.
- Used as a leaf arithmetic block inside datapaths that need an adder with explicit carry-in and carry-out.

Parameters:
- N, default 4, operand and sum width in bits; legal range is N >= 1.

Ports:
- clk  input  1  rising-edge clock; drives the output registers only.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  N  operand A, unsigned.
- B  input  N  operand B, unsigned.
- Cin  input  1  carry-in to bit 0.
- Sum  output  N  combinational sum bits, (A+B+Cin) mod 2^N.
- Cout  output  1  combinational carry-out of bit N-1.
- Sum_q  output  N  Sum registered on the rising edge of clk.
- Cout_q  output  1  Cout registered on the rising edge of clk.
- Ovf_q  output  1  registered signed overflow flag: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Combinational path:
  - {Cout,Sum} = A + B + Cin, evaluated as an (N+1)-bit result with no truncation.
  - Result range 0 .. 2^(N+1)-1; N=4 gives 0..31.
  - Built as a carry chain: c[0]=Cin; bit i computes s[i]=A[i]^B[i]^c[i] and c[i+1]=A[i]&B[i] | c[i]&(A[i]^B[i]); Cout=c[N].
  - Sum and Cout are valid after the input-to-output propagation delay, with zero clock cycles of latency.
  - They do not depend on clk or rst_n.
- Registered path:
  - On every rising edge of clk with rst_n=1: Sum_q<=Sum, Cout_q<=Cout, Ovf_q<=c[N-1]^c[N].
  - Latency is exactly 1 cycle, with no enable and no handshake; a new operand set is accepted every cycle.
- Reset:
  - rst_n=0 immediately forces Sum_q=0, Cout_q=0, Ovf_q=0, regardless of clk.
  - Combinational outputs keep tracking the inputs during reset.
  - On deassertion, the first rising edge captures the current inputs.
- Boundaries:
  - All-ones + all-ones + 1 gives Sum=all-ones, Cout=1.
  - 0+0+0 gives Sum=0, Cout=0.
  - All-ones + 0 + Cin=1 ripples through the full chain: Sum=0, Cout=1.
  - N=1 reduces to a single full adder; in that case Ovf_q = Cin ^ Cout.
- No X-propagation masking; the design is purely synthesizable, with no latches.

Decomposition:
- Sub-module full_adder (a, b, cin -> s, cout), instantiated N times with a generate loop; the carry chain is wired between the instances.
- No shared package needed. The default width constant may live in the project's common arithmetic package if one exists; otherwise N is a local parameter default.

Test Plan:
- Exhaustive N=4 sweep: drive {Cin,B,A}=i for i=0..511, one value every 5 time units -> {Cout,Sum}==A+B+Cin every step. Example: i=0x1F (A=15,B=1,Cin=0) -> Sum=0, Cout=1, result=16.
- Maximum case: A=15, B=15, Cin=1 -> Sum=15, Cout=1, result=31; next edge gives Sum_q=15, Cout_q=1, Ovf_q=0.
- Full-chain ripple: A=15, B=0, Cin=1 -> Sum=0, Cout=1; A=7, B=1, Cin=0 -> Sum=8, Cout=0, registered Ovf_q=1.
- Reset mid-operation: with registers holding Sum_q=9, assert rst_n=0 between edges -> Sum_q, Cout_q, Ovf_q all 0 immediately, while Sum still equals A+B+Cin. Release reset -> the first edge loads the current result.
- Latency: apply A=3,B=4,Cin=0 then A=5,B=6,Cin=1 on consecutive cycles -> Sum_q reads 7 then 12 (Cout_q 0 both times), each one edge after the inputs.
- Width check: N=8, A=200, B=100, Cin=1 -> Sum=45, Cout=1.

Source files
------------

// File: rtl/ripple_carry_adder_r_pkg.sv
// rtl/ripple_carry_adder_r_pkg.sv - shared width default for the ripple-carry adder
package ripple_carry_adder_r_pkg;

  localparam int RCA_DEFAULT_N = 4;

endpackage

// File: rtl/ripple_carry_adder_r_full_adder.sv
// rtl/ripple_carry_adder_r_full_adder.sv - single-bit full adder cell of the carry chain
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder_r.sv
// rtl/ripple_carry_adder_r.sv - N-bit ripple-carry adder with combinational and registered results
module ripple_carry_adder_r
  import ripple_carry_adder_r_pkg::*;
#(
  parameter int N = RCA_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic [N-1:0] Sum_q,
  output logic         Cout_q,
  output logic         Ovf_q
);

  logic [N:0]   c;
  logic [N-1:0] sum_d, sum_q;
  logic         cout_d, cout_q;
  logic         ovf_d, ovf_q;

  assign c[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (c[i]),
      .s    (Sum[i]),
      .cout (c[i+1])
    );
  end

  assign Cout = c[N];

  // Signed overflow: carry into the MSB disagrees with carry out of it (c[0]=Cin when N=1).
  always_comb begin
    sum_d  = Sum;
    cout_d = c[N];
    ovf_d  = c[N-1] ^ c[N];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Sum_q  = sum_q;
  assign Cout_q = cout_q;
  assign Ovf_q  = ovf_q;

endmodule

// File: tb/tb_ripple_carry_adder_r.sv
// tb/tb_ripple_carry_adder_r.sv - directed and table-driven bench for ripple_carry_adder_r
module tb_ripple_carry_adder_r;

  logic       clk;
  logic       rst_n;
  logic [3:0] a, b;
  logic       cin;
  logic [3:0] sum, sum_q;
  logic       cout, cout_q, ovf_q;

  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] sum8, sum8_q;
  logic       cout8, cout8_q, ovf8_q;

  int n_checks = 0;
  int n_fail   = 0;

  ripple_carry_adder_r #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin),
    .Sum(sum), .Cout(cout), .Sum_q(sum_q), .Cout_q(cout_q), .Ovf_q(ovf_q)
  );

  ripple_carry_adder_r #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8),
    .Sum(sum8), .Cout(cout8), .Sum_q(sum8_q), .Cout_q(cout8_q), .Ovf_q(ovf8_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    logic [4:0] exp5;
    logic [8:0] iv;

    tbl[0] = '{"max",       4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
    tbl[1] = '{"zero",      4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0};
    tbl[2] = '{"ripple",    4'd15, 4'd0,  1'b1, 4'd0,  1'b1, 1'b0};
    tbl[3] = '{"pos_ovf",   4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1};
    tbl[4] = '{"neg_ovf",   4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};
    tbl[5] = '{"3p4",       4'd3,  4'd4,  1'b0, 4'd7,  1'b0, 1'b0};
    tbl[6] = '{"5p6p1",     4'd5,  4'd6,  1'b1, 4'd12, 1'b0, 1'b1};
    tbl[7] = '{"9p6",       4'd9,  4'd6,  1'b0, 4'd15, 1'b0, 1'b0};

    rst_n = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    #3;
    chk("reset_sum_q",  sum_q,  0);
    chk("reset_cout_q", cout_q, 0);
    chk("reset_ovf_q",  ovf_q,  0);

    // Exhaustive combinational sweep, held in reset to also show the comb path ignores rst_n.
    for (int i = 0; i < 512; i++) begin
      iv = 9'(i);
      {cin, b, a} = iv;
      #4;
      exp5 = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      chk("sweep", {cout, sum}, exp5);
      #1;
    end
    chk("sweep_reset_held", {cout_q, ovf_q, sum_q}, 0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a = tbl[k].a; b = tbl[k].b; cin = tbl[k].cin;
      #1;
      chk({tbl[k].nm, "_sum"},  sum,  tbl[k].sum);
      chk({tbl[k].nm, "_cout"}, cout, tbl[k].cout);
      @(posedge clk); #1;
      chk({tbl[k].nm, "_sum_q"},  sum_q,  tbl[k].sum);
      chk({tbl[k].nm, "_cout_q"}, cout_q, tbl[k].cout);
      chk({tbl[k].nm, "_ovf_q"},  ovf_q,  tbl[k].ovf);
    end

    // Latency: each result appears exactly one edge after its inputs.
    @(negedge clk);
    a = 4'd3; b = 4'd4; cin = 1'b0;
    @(posedge clk); #1;
    chk("lat_first_sum_q", sum_q, 7);
    chk("lat_first_cout_q", cout_q, 0);
    @(negedge clk);
    a = 4'd5; b = 4'd6; cin = 1'b1;
    #1;
    chk("lat_hold_sum_q", sum_q, 7);
    @(posedge clk); #1;
    chk("lat_second_sum_q", sum_q, 12);
    chk("lat_second_cout_q", cout_q, 0);

    // Reset mid-operation, asserted between edges.
    @(negedge clk);
    a = 4'd4; b = 4'd5; cin = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_sum_q", sum_q, 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sum_q",  sum_q,  0);
    chk("async_rst_cout_q", cout_q, 0);
    chk("async_rst_ovf_q",  ovf_q,  0);
    chk("rst_comb_sum", sum, 9);
    @(negedge clk);
    rst_n = 1'b1;
    a = 4'd1; b = 4'd2; cin = 1'b0;
    #1;
    chk("post_rst_before_edge", sum_q, 0);
    @(posedge clk); #1;
    chk("post_rst_first_edge", sum_q, 3);

    // Width 8 instance.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; cin8 = 1'b1;
    #1;
    chk("w8_sum",  sum8,  45);
    chk("w8_cout", cout8, 1);
    @(posedge clk); #1;
    chk("w8_sum_q",  sum8_q,  45);
    chk("w8_cout_q", cout8_q, 1);
    chk("w8_ovf_q",  ovf8_q,  0);
    @(negedge clk);
    a8 = 8'd127; b8 = 8'd0; cin8 = 1'b1;
    #1;
    chk("w8_ovf_sum", sum8, 128);
    @(posedge clk); #1;
    chk("w8_ovf_q_set",  ovf8_q,  1);
    chk("w8_ovf_cout_q", cout8_q, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
